// File: rtl/regfile.sv
// Architectural register file: 32 x WIDTH, one synchronous write port, two combinational read ports.
// r0 is hardwired to zero; reset is asynchronous and clears every stored register.
module regfile #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_writeEnable,
  input  logic [4:0]       ctrl_writeReg,
  input  logic [WIDTH-1:0] data_writeReg,
  input  logic [4:0]       ctrl_readRegA,
  input  logic [4:0]       ctrl_readRegB,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB
);

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  logic [NREG-1:0]  sel;
  logic [NREG-1:0]  we;
  logic [WIDTH-1:0] rf_q [NREG];

  // One-hot destination decode gated by the write strobe; r0 never gets an enable.
  always_comb begin
    sel = '0;
    sel[ctrl_writeReg] = 1'b1;
    we  = sel & {NREG{ctrl_writeEnable}};
    we[0] = 1'b0;
  end

  assign rf_q[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
        rf_q[i] <= '0;
      end else if (we[i]) begin
        rf_q[i] <= data_writeReg;
      end
    end
  end

  // Read ports see pre-edge contents; forwarding is left to the pipeline.
  always_comb begin
    data_readRegA = '0;
    data_readRegB = '0;
    for (int unsigned j = 0; j < NREG; j++) begin
      if (ctrl_readRegA == AW'(j)) data_readRegA = rf_q[j];
      if (ctrl_readRegB == AW'(j)) data_readRegB = rf_q[j];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic
// compared against an array model of the architectural registers.
module tb_regfile;

  logic        clock;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [32];

  regfile #(.WIDTH(32)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  initial clock = 1'b0;
  always #50 clock = ~clock;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // One write cycle: drive after falling edge, commit at rising edge, drop strobe.
  task automatic do_write(input logic en, input logic [4:0] k, input logic [31:0] d);
    @(negedge clock);
    ctrl_writeEnable = en;
    ctrl_writeReg    = k;
    data_writeReg    = d;
    @(posedge clock);
    #1;
    if (en && k != 5'd0 && !ctrl_reset) model[k] = d;
    ctrl_writeEnable = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      ctrl_readRegA = 5'(i * 9);
      ctrl_readRegB = 5'(31 - i * 7);
      #1;
      total++;
      if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
        bad++;
        $display("FAIL reset_initial a=%0d b=%0d got A=%h B=%h want 0", ctrl_readRegA, ctrl_readRegB, data_readRegA, data_readRegB);
      end
    end
    @(negedge clock);
    ctrl_reset = 1'b0;
    model_clear();
    for (int k = 1; k < 32; k++) do_write(1'b1, 5'(k), 32'hFFFF_FFFF);
    ctrl_readRegA = 5'd31;
    #1;
    total++;
    if (data_readRegA !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL reset_prefill got %h want ffffffff", data_readRegA);
    end
    // Assert reset mid-cycle; all reads must be zero before the next rising edge.
    @(negedge clock);
    #1 ctrl_reset = 1'b1;
    model_clear();
    for (int k = 1; k < 32; k++) begin
      ctrl_readRegA = 5'(k);
      ctrl_readRegB = 5'(k);
      #1;
      total++;
      if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
        bad++;
        $display("FAIL reset_async r%0d got A=%h B=%h want 0", k, data_readRegA, data_readRegB);
      end
    end
    @(negedge clock);
    ctrl_reset = 1'b0;
  endtask

  task automatic test_sweep();
    for (int k = 1; k < 32; k++) do_write(1'b1, 5'(k), 32'hA500_0000 | 32'(k));
    for (int k = 1; k < 32; k++) begin
      ctrl_readRegA = 5'(k);
      ctrl_readRegB = 5'(32 - k);
      #1;
      total++;
      if (data_readRegA !== (32'hA500_0000 | 32'(k))) begin
        bad++;
        $display("FAIL sweep_a r%0d got %h want %h", k, data_readRegA, 32'hA500_0000 | 32'(k));
      end
      total++;
      if (data_readRegB !== (32'hA500_0000 | 32'(32 - k))) begin
        bad++;
        $display("FAIL sweep_b r%0d got %h want %h", 32 - k, data_readRegB, 32'hA500_0000 | 32'(32 - k));
      end
    end
  endtask

  task automatic test_r0();
    do_write(1'b1, 5'd0, 32'hDEAD_BEEF);
    ctrl_readRegA = 5'd0;
    ctrl_readRegB = 5'd0;
    #1;
    total++;
    if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
      bad++;
      $display("FAIL r0_read got A=%h B=%h want 0", data_readRegA, data_readRegB);
    end
    for (int k = 1; k < 32; k++) begin
      ctrl_readRegA = 5'(k);
      #1;
      total++;
      if (data_readRegA !== model[k]) begin
        bad++;
        $display("FAIL r0_side r%0d got %h want %h", k, data_readRegA, model[k]);
      end
    end
  endtask

  task automatic test_enable_gating();
    do_write(1'b1, 5'd7, 32'h0000_0055);
    do_write(1'b0, 5'd7, 32'h1234_5678);
    ctrl_readRegA = 5'd7;
    ctrl_readRegB = 5'd7;
    #1;
    total++;
    if (data_readRegA !== 32'h0000_0055 || data_readRegB !== 32'h0000_0055) begin
      bad++;
      $display("FAIL enable_gating got A=%h B=%h want 00000055", data_readRegA, data_readRegB);
    end
  endtask

  task automatic test_same_cycle();
    do_write(1'b1, 5'd5, 32'h1111_1111);
    do_write(1'b1, 5'd6, 32'h6666_0006);
    @(negedge clock);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd5;
    data_writeReg    = 32'h2222_2222;
    ctrl_readRegA    = 5'd5;
    ctrl_readRegB    = 5'd6;
    #1;
    total++;
    if (data_readRegA !== 32'h1111_1111) begin
      bad++;
      $display("FAIL same_cycle_pre got %h want 11111111", data_readRegA);
    end
    total++;
    if (data_readRegB !== 32'h6666_0006) begin
      bad++;
      $display("FAIL same_cycle_b_pre got %h want 66660006", data_readRegB);
    end
    @(posedge clock);
    #1;
    ctrl_writeEnable = 1'b0;
    model[5] = 32'h2222_2222;
    total++;
    if (data_readRegA !== 32'h2222_2222) begin
      bad++;
      $display("FAIL same_cycle_post got %h want 22222222", data_readRegA);
    end
    total++;
    if (data_readRegB !== 32'h6666_0006) begin
      bad++;
      $display("FAIL same_cycle_b_post got %h want 66660006", data_readRegB);
    end
    // Back-to-back writes to one register: the later edge wins.
    do_write(1'b1, 5'd5, 32'h3333_3333);
    do_write(1'b1, 5'd5, 32'h4444_4444);
    #1;
    total++;
    if (data_readRegA !== 32'h4444_4444) begin
      bad++;
      $display("FAIL back_to_back got %h want 44444444", data_readRegA);
    end
  endtask

  task automatic test_reset_collision();
    do_write(1'b1, 5'd9, 32'h0909_0909);
    @(negedge clock);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd9;
    data_writeReg    = 32'hCAFE_F00D;
    ctrl_reset       = 1'b1;
    ctrl_readRegA    = 5'd9;
    ctrl_readRegB    = 5'd5;
    @(posedge clock);
    #1;
    model_clear();
    total++;
    if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
      bad++;
      $display("FAIL reset_collision got A=%h B=%h want 0", data_readRegA, data_readRegB);
    end
    @(negedge clock);
    ctrl_writeEnable = 1'b0;
    ctrl_reset       = 1'b0;
    #1;
    total++;
    if (data_readRegA !== 32'h0) begin
      bad++;
      $display("FAIL reset_release got %h want 0", data_readRegA);
    end
    do_write(1'b1, 5'd9, 32'h0000_0001);
    total++;
    if (data_readRegA !== 32'h0000_0001) begin
      bad++;
      $display("FAIL post_reset_write got %h want 00000001", data_readRegA);
    end
  endtask

  task automatic test_random();
    logic        en;
    logic [4:0]  k;
    logic [31:0] d;
    for (int n = 0; n < 300; n++) begin
      en = 1'($urandom_range(0, 3) != 0);
      k  = 5'($urandom_range(0, 31));
      d  = $urandom;
      @(negedge clock);
      ctrl_writeEnable = en;
      ctrl_writeReg    = k;
      data_writeReg    = d;
      ctrl_readRegA    = (n % 4 == 0) ? k : 5'($urandom_range(0, 31));
      ctrl_readRegB    = 5'($urandom_range(0, 31));
      #1;
      total++;
      if (data_readRegA !== model[ctrl_readRegA] || data_readRegB !== model[ctrl_readRegB]) begin
        bad++;
        $display("FAIL random_pre n=%0d A[r%0d]=%h want %h B[r%0d]=%h want %h", n, ctrl_readRegA, data_readRegA,
                 model[ctrl_readRegA], ctrl_readRegB, data_readRegB, model[ctrl_readRegB]);
      end
      @(posedge clock);
      #1;
      if (en && k != 5'd0) model[k] = d;
      ctrl_writeEnable = 1'b0;
      total++;
      if (data_readRegA !== model[ctrl_readRegA] || data_readRegB !== model[ctrl_readRegB]) begin
        bad++;
        $display("FAIL random_post n=%0d A[r%0d]=%h want %h B[r%0d]=%h want %h", n, ctrl_readRegA, data_readRegA,
                 model[ctrl_readRegA], ctrl_readRegB, data_readRegB, model[ctrl_readRegB]);
      end
    end
  endtask

  initial begin
    ctrl_reset       = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'h0;
    ctrl_readRegA    = 5'd0;
    ctrl_readRegB    = 5'd0;
    model_clear();
    test_reset();
    test_sweep();
    test_r0();
    test_enable_gating();
    test_same_cycle();
    test_reset_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
